// File: rtl/pg_ctrl_md.sv
// Per-domain light/deep-sleep power-gating sequencers; outputs are registered from next state, so each is valid in the first cycle of its state.
// No backpressure: wfi is sampled every cycle and wake_req is 2-flop synchronised. PG_WAKE_STAGGER_EN serialises MOTHER_WAKE across domains.
module pg_ctrl_md #(
  parameter int               N_DOM       = 2,
  parameter int               CNT_W       = 40,
  parameter logic [CNT_W-1:0] THRESHOLD   = 40'd1000,
  parameter int               SAVE_CYC    = 3,
  parameter int               MSLEEP_CYC  = 3,
  parameter int               MWAKE_CYC   = 3,
  parameter int               RST_CYC     = 8,
  parameter int               RESTORE_CYC = 3
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic [N_DOM-1:0] wfi,
  input  logic [N_DOM-1:0] wake_req,
  output logic [N_DOM-1:0] cpu_clk_g,
  output logic [N_DOM-1:0] save,
  output logic [N_DOM-1:0] restore,
  output logic [N_DOM-1:0] isolation_on,
  output logic [N_DOM-1:0] mother_sleep,
  output logic [N_DOM-1:0] daughter_sleep,
  output logic [N_DOM-1:0] pg_resetn,
  output logic [N_DOM-1:0] deep_sleep
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LIGHT, ST_SAVE, ST_ISO_ON, ST_MSLEEP,
    ST_DSLEEP, ST_MWAKE, ST_RESET, ST_RESTORE, ST_CLK_ON
  } state_t;

  localparam logic [CNT_W-1:0] THR_LAST     = THRESHOLD - 1'b1;
  localparam logic [3:0]       SAVE_LAST    = 4'(SAVE_CYC - 1);
  localparam logic [3:0]       MSLEEP_LAST  = 4'(MSLEEP_CYC - 1);
  localparam logic [3:0]       MWAKE_LAST   = 4'(MWAKE_CYC - 1);
  localparam logic [3:0]       RST_LAST     = 4'(RST_CYC - 1);
  localparam logic [3:0]       RESTORE_LAST = 4'(RESTORE_CYC - 1);

  logic [N_DOM-1:0] wake_m, wake_s;
  state_t           state_q [N_DOM];
  state_t           state_d [N_DOM];
  logic [3:0]       phase_q [N_DOM];
  logic [3:0]       phase_d [N_DOM];
  logic [CNT_W-1:0] lcnt_q  [N_DOM];
  logic [CNT_W-1:0] lcnt_d  [N_DOM];
  logic [N_DOM-1:0] gate_q, gate_d;
  logic [N_DOM-1:0] dsl_go;
  logic [N_DOM-1:0] save_d, restore_d, iso_d, msleep_d, dsleep_d, resetn_d, deep_d;

`ifdef PG_WAKE_STAGGER_EN
  logic [N_DOM-1:0] pend_q, pend_d, ds_req;
  logic             any_mw, granted;

  // Lowest-index waiting domain wins, and only while nobody is in MOTHER_WAKE.
  always_comb begin
    any_mw  = 1'b0;
    granted = 1'b0;
    dsl_go  = '0;
    ds_req  = '0;
    for (int i = 0; i < N_DOM; i++) begin
      if (state_q[i] == ST_MWAKE) any_mw = 1'b1;
    end
    for (int i = 0; i < N_DOM; i++) begin
      ds_req[i] = (state_q[i] == ST_DSLEEP) && (wake_s[i] || pend_q[i]);
      if (ds_req[i] && !any_mw && !granted) begin
        dsl_go[i] = 1'b1;
        granted   = 1'b1;
      end
    end
    pend_d = ds_req & ~dsl_go;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) pend_q <= '0;
    else           pend_q <= pend_d;
  end
`else
  assign dsl_go = wake_s;
`endif

  always_comb begin
    save_d    = '0;
    restore_d = '0;
    iso_d     = '0;
    msleep_d  = '0;
    dsleep_d  = '0;
    resetn_d  = '1;
    deep_d    = '0;
    gate_d    = '0;
    for (int i = 0; i < N_DOM; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE:    if (wfi[i] && !wake_s[i]) state_d[i] = ST_LIGHT;
        ST_LIGHT:   if (wake_s[i]) state_d[i] = ST_IDLE;
                    else if (lcnt_q[i] == THR_LAST) state_d[i] = ST_SAVE;
        ST_SAVE:    if (wake_s[i]) state_d[i] = ST_IDLE;
                    else if (phase_q[i] == SAVE_LAST) state_d[i] = ST_ISO_ON;
        ST_ISO_ON:  state_d[i] = wake_s[i] ? ST_CLK_ON : ST_MSLEEP;
        ST_MSLEEP:  if (wake_s[i]) state_d[i] = ST_RESET;
                    else if (phase_q[i] == MSLEEP_LAST) state_d[i] = ST_DSLEEP;
        ST_DSLEEP:  if (dsl_go[i]) state_d[i] = ST_MWAKE;
        // Wake is deliberately ignored from here on: the power-up sequence must complete.
        ST_MWAKE:   if (phase_q[i] == MWAKE_LAST) state_d[i] = ST_RESET;
        ST_RESET:   if (phase_q[i] == RST_LAST) state_d[i] = ST_RESTORE;
        ST_RESTORE: if (phase_q[i] == RESTORE_LAST) state_d[i] = ST_CLK_ON;
        ST_CLK_ON:  state_d[i] = ST_IDLE;
        default:    state_d[i] = ST_IDLE;
      endcase

      if (state_d[i] != state_q[i])   phase_d[i] = '0;
      else if (phase_q[i] != 4'hf)    phase_d[i] = phase_q[i] + 4'd1;
      else                            phase_d[i] = phase_q[i];

      if (state_q[i] == ST_LIGHT && state_d[i] == ST_LIGHT)
        lcnt_d[i] = (lcnt_q[i] != '1) ? lcnt_q[i] + 1'b1 : lcnt_q[i];
      else
        lcnt_d[i] = '0;

      save_d[i]    = (state_d[i] == ST_SAVE);
      restore_d[i] = (state_d[i] == ST_RESTORE);
      resetn_d[i]  = (state_d[i] != ST_RESET);
      iso_d[i]     = state_d[i] inside {ST_ISO_ON, ST_MSLEEP, ST_DSLEEP, ST_MWAKE, ST_RESET, ST_RESTORE};
      msleep_d[i]  = state_d[i] inside {ST_MSLEEP, ST_DSLEEP};
      dsleep_d[i]  = state_d[i] inside {ST_DSLEEP, ST_MWAKE};
      deep_d[i]    = (state_d[i] == ST_DSLEEP);
      gate_d[i]    = state_d[i] inside {ST_LIGHT, ST_SAVE, ST_ISO_ON, ST_MSLEEP, ST_DSLEEP, ST_MWAKE, ST_RESET};
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wake_m         <= '0;
      wake_s         <= '0;
      gate_q         <= '0;
      save           <= '0;
      restore        <= '0;
      isolation_on   <= '0;
      mother_sleep   <= '0;
      daughter_sleep <= '0;
      pg_resetn      <= '1;
      deep_sleep     <= '0;
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= ST_IDLE;
        phase_q[i] <= '0;
        lcnt_q[i]  <= '0;
      end
    end else begin
      wake_m         <= wake_req;
      wake_s         <= wake_m;
      gate_q         <= gate_d;
      save           <= save_d;
      restore        <= restore_d;
      isolation_on   <= iso_d;
      mother_sleep   <= msleep_d;
      daughter_sleep <= dsleep_d;
      pg_resetn      <= resetn_d;
      deep_sleep     <= deep_d;
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= state_d[i];
        phase_q[i] <= phase_d[i];
        lcnt_q[i]  <= lcnt_d[i];
      end
    end
  end

  // Behavioural stand-in for the vendor ICG cell.
  assign cpu_clk_g = {N_DOM{cpu_clk}} & ~gate_q;

endmodule

// File: tb/tb_pg_ctrl_md.sv
// Bench for pg_ctrl_md: directed power-gating scenarios plus random wfi/wake traffic against a phase-timeline model.
module tb_pg_ctrl_md;
  localparam int ND  = 2;
  localparam int THR = 10;
  // Phase labels in sequence order: a timed-out phase advances to the next label.
  localparam int M_IDLE = 0, M_LIGHT = 1, M_SAVE = 2, M_ISO = 3, M_MSL = 4,
                 M_DSL = 5, M_MWK = 6, M_RST = 7, M_RSTR = 8, M_CLKON = 9;

  logic          cpu_clk  = 1'b0;
  logic          cpu_rstn = 1'b0;
  logic [ND-1:0] wfi      = '0;
  logic [ND-1:0] wake_req = '0;
  logic [ND-1:0] cpu_clk_g, save, restore, isolation_on, mother_sleep;
  logic [ND-1:0] daughter_sleep, pg_resetn, deep_sleep;

  int   tests = 0;
  int   fails = 0;
  int   m_st   [ND];
  int   m_left [ND];
  logic m_w1   [ND];
  logic m_ws   [ND];
  logic m_pend [ND];

  pg_ctrl_md #(.N_DOM(ND), .THRESHOLD(40'(THR))) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .wfi(wfi), .wake_req(wake_req),
    .cpu_clk_g(cpu_clk_g), .save(save), .restore(restore), .isolation_on(isolation_on),
    .mother_sleep(mother_sleep), .daughter_sleep(daughter_sleep),
    .pg_resetn(pg_resetn), .deep_sleep(deep_sleep)
  );

  initial forever #5 cpu_clk = ~cpu_clk;

  function automatic int dur(input int s);
    case (s)
      M_LIGHT:                      return THR;
      M_SAVE, M_MSL, M_MWK, M_RSTR: return 3;
      M_ISO, M_CLKON:               return 1;
      M_RST:                        return 8;
      default:                      return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_st[i] = M_IDLE; m_left[i] = 0; m_w1[i] = 1'b0; m_ws[i] = 1'b0; m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_tick();
    int   s, n;
    logic ws;
`ifdef PG_WAKE_STAGGER_EN
    logic busy, granted;
`endif
    if (!cpu_rstn) begin
      model_reset();
      return;
    end
`ifdef PG_WAKE_STAGGER_EN
    busy = 1'b0;
    granted = 1'b0;
    for (int i = 0; i < ND; i++) if (m_st[i] == M_MWK) busy = 1'b1;
`endif
    for (int i = 0; i < ND; i++) begin
      s = m_st[i]; n = s; ws = m_ws[i];
      if (s == M_IDLE) begin
        if (wfi[i] && !ws) n = M_LIGHT;
      end else if (s == M_DSL) begin
`ifdef PG_WAKE_STAGGER_EN
        if (ws) m_pend[i] = 1'b1;
        if (m_pend[i] && !busy && !granted) begin
          n = M_MWK; granted = 1'b1; m_pend[i] = 1'b0;
        end
`else
        if (ws) n = M_MWK;
`endif
      end
      else if (ws && (s == M_LIGHT || s == M_SAVE)) n = M_IDLE;
      else if (ws && s == M_ISO) n = M_CLKON;
      else if (ws && s == M_MSL) n = M_RST;
      else if (m_left[i] == 1) n = (s == M_CLKON) ? M_IDLE : s + 1;
      if (n != s) begin
        m_st[i] = n; m_left[i] = dur(n);
      end else if (m_left[i] > 1) begin
        m_left[i]--;
      end
    end
    for (int i = 0; i < ND; i++) begin
      m_ws[i] = m_w1[i];
      m_w1[i] = wake_req[i];
    end
  endtask

  task automatic chk(input string tag, input logic [ND-1:0] obs, input logic [ND-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [ND-1:0] e_save, e_rest, e_iso, e_ms, e_ds, e_rn, e_deep, e_clk;
    int s;
    for (int i = 0; i < ND; i++) begin
      s = m_st[i];
      e_save[i] = (s == M_SAVE);
      e_rest[i] = (s == M_RSTR);
      e_rn[i]   = (s != M_RST);
      e_iso[i]  = (s >= M_ISO && s <= M_RSTR);
      e_ms[i]   = (s == M_MSL || s == M_DSL);
      e_ds[i]   = (s == M_DSL || s == M_MWK);
      e_deep[i] = (s == M_DSL);
      e_clk[i]  = cpu_clk && !(s >= M_LIGHT && s <= M_RST);
    end
    chk("save", save, e_save);
    chk("restore", restore, e_rest);
    chk("pg_resetn", pg_resetn, e_rn);
    chk("isolation_on", isolation_on, e_iso);
    chk("mother_sleep", mother_sleep, e_ms);
    chk("daughter_sleep", daughter_sleep, e_ds);
    chk("deep_sleep", deep_sleep, e_deep);
    chk("cpu_clk_g", cpu_clk_g, e_clk);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge cpu_clk);
      model_tick();
      #1;
      check_all();
    end
  endtask

  initial begin
    logic [ND-1:0] mw;
    int first0, first1;
    model_reset();

    step(2);
    chk("rst_pg_resetn", pg_resetn, 2'b11);
    chk("rst_iso", isolation_on, 2'b00);
    chk("rst_clk_g", cpu_clk_g, 2'b11);
    cpu_rstn = 1'b1;
    step(2);

    // dom0 enters deep sleep, dom1 keeps running
    wfi = 2'b01; step(1); wfi = 2'b00;
    chk("a_clk_gated", cpu_clk_g, 2'b10);
    step(THR - 1); chk("a_no_save_yet", save, 2'b00);
    step(1);       chk("a_save", save, 2'b01);
    step(7);       chk("a_deep", deep_sleep, 2'b01);
    chk("a_dom1_clk", cpu_clk_g, 2'b10);

    // wake from deep sleep
    wake_req = 2'b01; step(1); wake_req = 2'b00; step(2);
    chk("b_mwake_ds", daughter_sleep, 2'b01);
    chk("b_mwake_ms", mother_sleep, 2'b00);
    step(3); chk("b_reset", pg_resetn, 2'b10);
    step(8); chk("b_restore", restore, 2'b01);
    chk("b_restore_clk", cpu_clk_g, 2'b11);
    step(3); chk("b_iso_off", isolation_on, 2'b00);
    step(1);

    // wake during SAVE cycle 2, then full re-entry proves the light counter cleared
    wfi = 2'b01; step(1); wfi = 2'b00;
    step(THR - 1);
    wake_req = 2'b01; step(1); wake_req = 2'b00;
    step(1); chk("c_save2", save, 2'b01);
    step(1); chk("c_save_drop", save, 2'b00);
    chk("c_no_iso", isolation_on, 2'b00);
    step(2);
    wfi = 2'b01; step(1); wfi = 2'b00;
    step(THR - 1); chk("c_relight", save, 2'b00);
    step(1);       chk("c_resave", save, 2'b01);

    // wake during MOTHER_SLEEP skips DAUGHTER_SLEEP
    step(3);
    wake_req = 2'b01; step(1); wake_req = 2'b00;
    step(2); chk("d_ms_reset", pg_resetn, 2'b10);
    chk("d_ms_no_deep", deep_sleep, 2'b00);
    step(8); chk("d_ms_restore", restore, 2'b01);
    step(4);

    // wfi and synchronised wake in the same IDLE cycle
    step(2);
    wake_req = 2'b01; step(1); wake_req = 2'b00; step(1);
    wfi = 2'b01; step(1); wfi = 2'b00;
    chk("d_stay_idle", cpu_clk_g, 2'b11);
    step(2);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < ND; i++) begin
        wfi[i]      = ($urandom_range(0, 5) == 0);
        wake_req[i] = ($urandom_range(0, 60) == 0);
      end
      step(1);
    end
    wfi = '0; wake_req = '0;
    cpu_rstn = 1'b0; model_reset();
    step(1);
    cpu_rstn = 1'b1;
    step(2);

    // both domains deep, simultaneous wake
    wfi = 2'b11; step(1); wfi = 2'b00;
    step(17); chk("e_both_deep", deep_sleep, 2'b11);
    wake_req = 2'b11; step(1); wake_req = 2'b00; step(1);
    first0 = -1; first1 = -1;
    for (int c = 0; c < 14; c++) begin
      step(1);
      mw = daughter_sleep & ~mother_sleep;
`ifdef PG_WAKE_STAGGER_EN
      chk("e_mw_not_both", {1'b0, (mw == 2'b11)}, 2'b00);
`endif
      if (mw[0] && first0 < 0) first0 = c;
      if (mw[1] && first1 < 0) first1 = c;
    end
    chk_int("e_dom0_mw_start", first0, 0);
`ifdef PG_WAKE_STAGGER_EN
    chk_int("e_dom1_mw_start", first1, 4);
`else
    chk_int("e_dom1_mw_start", first1, 0);
`endif
    step(20);

    // reset asserted while dom0 is in its RESET phase
    wfi = 2'b01; step(1); wfi = 2'b00;
    step(17);
    wake_req = 2'b01; step(1); wake_req = 2'b00;
    step(5); step(2);
    chk("f_in_reset", pg_resetn, 2'b10);
    #2;
    cpu_rstn = 1'b0; model_reset();
    #1;
    chk("f_async_resetn", pg_resetn, 2'b11);
    chk("f_async_iso", isolation_on, 2'b00);
    chk("f_async_clk", cpu_clk_g, 2'b11);
    check_all();
    step(1);
    cpu_rstn = 1'b1;
    step(3);
    chk("f_idle_clk", cpu_clk_g, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
